timer_array: RTL and testbench
==============================

// Module: timer_array
// PURPOSE
//  Bank of NCH independent up-counting timers, each with a WIDTH-bit terminal value.
//  Each channel runs in one-shot or periodic mode and can be started, stopped and restarted.
//  Expiry gives a one-cycle tick and a sticky done flag; irq is the OR of the done flags.
//  Sits beside the controller datapath; supplies timeouts and periodic events to the FSMs.
// PARAMETERS
//  NCH    4  number of independent timer channels (>=1)
//  WIDTH  8  counter / terminal-value width in bits (>=2)
// PORTS
//  clk      in   1          rising-edge clock; the only clock
//  reset    in   1          synchronous, active-low reset (0 = reset, sampled on posedge clk)
//  start    in   NCH        per-channel start/restart request, level sampled each edge
//  stop     in   NCH        per-channel stop request
//  mode     in   NCH        per-channel mode, sampled with start: 0 = one-shot, 1 = periodic
//  value    in   NCH*WIDTH  per-channel terminal value, ch i = value[i*WIDTH +: WIDTH], sampled with start
//  irq_clr  in   NCH        per-channel clear of done
//  busy     out  NCH        channel is in RUN
//  tick     out  NCH        one-cycle expiry pulse
//  done     out  NCH        sticky expiry flag
//  count    out  NCH*WIDTH  current counter value per channel
//  irq      out  1          |done
// BEHAVIOUR
//  Reset: when reset==0 at a posedge, all channels go to IDLE and every output is 0.
//   All internal period/mode latches are 0. A reset mid-count aborts with no tick.
//  Per-channel FSM: IDLE, RUN. All outputs are registered, except irq = |done.
//  Priority at each edge, per channel: reset > start > stop > expiry > increment.
//  start=1: counter<=0, period<=value slice, pmode<=mode, state<=RUN.
//   This is accepted in IDLE or RUN (restart); a restart in the expiry cycle suppresses that tick.
//  stop=1 (no start): state<=IDLE, counter holds its value, no tick. A stop while IDLE has no effect.
//  RUN with counter==period: tick<=1 for one cycle, done<=1.
//   One-shot: state<=IDLE, counter holds at period.
//   Periodic: counter<=0, stays in RUN.
//  RUN with counter!=period: counter<=counter+1, modulo 2^WIDTH.
//   Wrap cannot occur because period is at most 2^WIDTH-1.
//  Latency: if start is sampled at edge E0, tick is high after edge E0+value+1 for exactly one cycle.
//   Periodic mode repeats every value+1 cycles. value=0 ticks 1 cycle after start, and every cycle if periodic.
//  value/mode changes while in RUN are ignored until the next start.
//  done: set on expiry, cleared by irq_clr. If set and clear occur in the same edge, set wins.
//   start does not clear done.
//  tick is 0 on every edge without an expiry. busy==1 exactly when state==RUN.
//  Channels are fully independent; simultaneous events on different channels do not interact.
// TESTING
//  (NCH=4, WIDTH=8)
//  1 reset=0 for 2 cycles with start=4'hF -> busy/tick/done/count/irq all 0; release -> still 0 until a start.
//  2 ch0 one-shot value=5, start 1 cycle -> tick[0] high once, 6 cycles after start edge; done[0]=1, irq=1;
//    busy[0] falls in the same edge; count0 holds 5; irq_clr[0] -> done[0]=0, irq=0.
//  3 ch1 periodic value=3 -> tick[1] every 4 cycles for 5 periods; count1 sequence 0,1,2,3,0,...;
//    stop at count=2 -> busy=0, count holds 2, no further tick.
//  4 ch2 one-shot value=10, restart at count=7 -> count back to 0, tick 11 cycles after the restart only;
//    start+stop in the same cycle -> runs (start wins).
//  5 ch3 periodic value=0 -> tick every cycle; irq_clr held high concurrently -> done stays 1 (set wins);
//    value changed to 9 mid-run -> period unchanged.
//  6 all 4 channels started with values 2,4,6,8, then reset=0 at cycle 5 -> ticks only from ch0
//    before the reset, all outputs 0 after.

Source files
------------

// File: rtl/timer_array_if.sv
// Control/status bundle for the timer bank: per-channel start/stop/mode/value/clear
// requests in, per-channel busy/tick/done/count and the combined irq out.
interface timer_array_if #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8
);
   logic [NCH-1:0]       start;
   logic [NCH-1:0]       stop;
   logic [NCH-1:0]       mode;
   logic [NCH*WIDTH-1:0] value;
   logic [NCH-1:0]       irq_clr;
   logic [NCH-1:0]       busy;
   logic [NCH-1:0]       tick;
   logic [NCH-1:0]       done;
   logic [NCH*WIDTH-1:0] count;
   logic                 irq;

   modport master (
      output start, stop, mode, value, irq_clr,
      input  busy, tick, done, count, irq
   );

   modport slave (
      input  start, stop, mode, value, irq_clr,
      output busy, tick, done, count, irq
   );
endinterface

// File: rtl/timer_array.sv
// Bank of NCH independent up-counting timers with one-shot/periodic modes,
// a one-cycle expiry tick, a sticky done flag per channel and an OR'ed irq.
module timer_array #(
   parameter int NCH   = 4,
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   timer_array_if.slave   bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   logic [NCH-1:0]       busy_v;
   logic [NCH-1:0]       tick_v;
   logic [NCH-1:0]       done_v;
   logic [NCH*WIDTH-1:0] count_v;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t           state, state_nxt;
      logic [WIDTH-1:0] counter, counter_nxt;
      logic [WIDTH-1:0] period, period_nxt;
      logic             pmode, pmode_nxt;
      logic             tick_r, tick_nxt;
      logic             done_r, done_nxt;

      always_ff @(posedge clk) begin
         if (!reset) begin
            state   <= IDLE;
            counter <= '0;
            period  <= '0;
            pmode   <= 1'b0;
            tick_r  <= 1'b0;
            done_r  <= 1'b0;
         end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
            period  <= period_nxt;
            pmode   <= pmode_nxt;
            tick_r  <= tick_nxt;
            done_r  <= done_nxt;
         end
      end

      // Priority: start > stop > expiry > increment; a set of done beats irq_clr.
      always_comb begin
         state_nxt   = state;
         counter_nxt = counter;
         period_nxt  = period;
         pmode_nxt   = pmode;
         tick_nxt    = 1'b0;
         done_nxt    = done_r & ~bus.irq_clr[i];
         if (bus.start[i]) begin
            state_nxt   = RUN;
            counter_nxt = '0;
            period_nxt  = bus.value[i*WIDTH +: WIDTH];
            pmode_nxt   = bus.mode[i];
         end else if (bus.stop[i]) begin
            state_nxt = IDLE;
         end else if (state == RUN) begin
            if (counter == period) begin
               tick_nxt = 1'b1;
               done_nxt = 1'b1;
               if (pmode) begin
                  counter_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               counter_nxt = counter + WIDTH'(1);
            end
         end
      end

      assign busy_v[i]                  = (state == RUN);
      assign tick_v[i]                  = tick_r;
      assign done_v[i]                  = done_r;
      assign count_v[i*WIDTH +: WIDTH]  = counter;
   end

   assign bus.busy  = busy_v;
   assign bus.tick  = tick_v;
   assign bus.done  = done_v;
   assign bus.count = count_v;
   assign bus.irq   = |done_v;
endmodule

// File: tb/tb_timer_array.sv
// Self-checking bench for timer_array: directed vector table, corner-case sequences
// and randomized traffic compared every cycle against an elapsed-time reference model.
module tb_timer_array;
   localparam int NCH   = 4;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   timer_array_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();
   timer_array #(.NCH(NCH), .WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a running channel is described by cycles elapsed since its start.
   bit m_active [NCH];
   int m_k      [NCH];
   int m_per    [NCH];
   bit m_pm     [NCH];
   int m_hold   [NCH];
   bit m_done   [NCH];
   bit m_tick   [NCH];

   typedef struct {
      logic       start0, stop0, mode0, clr0;
      logic [7:0] val0;
      logic       e_busy, e_tick, e_done, e_irq;
      logic [7:0] e_count;
   } vec_t;
   vec_t vecs [13];

   function automatic vec_t mk(logic st, logic sp, logic md, logic cl, logic [7:0] v,
                               logic eb, logic et, logic ed, logic ei, logic [7:0] ec);
      vec_t r;
      r.start0 = st; r.stop0 = sp; r.mode0 = md; r.clr0 = cl; r.val0 = v;
      r.e_busy = eb; r.e_tick = et; r.e_done = ed; r.e_irq = ei; r.e_count = ec;
      return r;
   endfunction

   function automatic int model_count(int c);
      if (m_active[c]) return m_pm[c] ? (m_k[c] % (m_per[c] + 1)) : m_k[c];
      return m_hold[c];
   endfunction

   task automatic model_edge();
      for (int c = 0; c < NCH; c++) begin
         bit nd;
         if (!reset) begin
            m_active[c] = 0; m_k[c] = 0; m_per[c] = 0; m_pm[c] = 0;
            m_hold[c] = 0; m_done[c] = 0; m_tick[c] = 0;
         end else begin
            m_tick[c] = 0;
            nd = m_done[c] & ~bus.irq_clr[c];
            if (bus.start[c]) begin
               m_active[c] = 1; m_k[c] = 0;
               m_per[c] = int'(bus.value[c*WIDTH +: WIDTH]);
               m_pm[c] = bus.mode[c];
            end else if (bus.stop[c]) begin
               if (m_active[c]) begin
                  m_hold[c] = model_count(c);
                  m_active[c] = 0;
               end
            end else if (m_active[c]) begin
               m_k[c]++;
               if (m_pm[c]) begin
                  if (m_k[c] % (m_per[c] + 1) == 0) m_tick[c] = 1;
               end else if (m_k[c] == m_per[c] + 1) begin
                  m_tick[c] = 1; m_active[c] = 0; m_hold[c] = m_per[c];
               end
            end
            if (m_tick[c]) nd = 1;
            m_done[c] = nd;
         end
      end
   endtask

   task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [NCH-1:0]       eb, et, ed;
      logic [NCH*WIDTH-1:0] ec;
      for (int c = 0; c < NCH; c++) begin
         eb[c] = m_active[c];
         et[c] = m_tick[c];
         ed[c] = m_done[c];
         ec[c*WIDTH +: WIDTH] = WIDTH'(model_count(c));
      end
      check_output("busy",  32'(bus.busy),  32'(eb));
      check_output("tick",  32'(bus.tick),  32'(et));
      check_output("done",  32'(bus.done),  32'(ed));
      check_output("count", 32'(bus.count), 32'(ec));
      check_output("irq",   32'(bus.irq),   32'(|ed));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic apply_stimulus(logic [NCH-1:0] st, logic [NCH-1:0] sp, logic [NCH-1:0] md,
                                 logic [NCH-1:0] cl);
      bus.start = st; bus.stop = sp; bus.mode = md; bus.irq_clr = cl;
   endtask

   int ticks [NCH];
   int tick_at;
   bit found;

   initial begin
      vecs[0]  = mk(1, 0, 0, 0, 8'd5, 1, 0, 0, 0, 8'd0);
      vecs[1]  = mk(0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 8'd1);
      vecs[2]  = mk(0, 0, 0, 0, 8'd9, 1, 0, 0, 0, 8'd2);
      vecs[3]  = mk(0, 0, 1, 0, 8'd0, 1, 0, 0, 0, 8'd3);
      vecs[4]  = mk(0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 8'd4);
      vecs[5]  = mk(0, 0, 0, 0, 8'd0, 1, 0, 0, 0, 8'd5);
      vecs[6]  = mk(0, 0, 0, 0, 8'd0, 0, 1, 1, 1, 8'd5);
      vecs[7]  = mk(0, 0, 0, 0, 8'd0, 0, 0, 1, 1, 8'd5);
      vecs[8]  = mk(0, 0, 0, 1, 8'd0, 0, 0, 0, 0, 8'd5);
      vecs[9]  = mk(0, 1, 0, 0, 8'd0, 0, 0, 0, 0, 8'd5);
      vecs[10] = mk(1, 0, 1, 0, 8'd0, 1, 0, 0, 0, 8'd0);
      vecs[11] = mk(0, 0, 0, 0, 8'd0, 1, 1, 1, 1, 8'd0);
      vecs[12] = mk(0, 1, 0, 0, 8'd0, 0, 0, 1, 1, 8'd0);

      // Reset held with every start asserted, then released with no start.
      reset = 1'b0;
      apply_stimulus('1, '0, '0, '0);
      bus.value = 32'h0403_0201;
      step();
      step();
      reset = 1'b1;
      apply_stimulus('0, '0, '0, '0);
      step();
      step();
      check_output("idle after reset irq", 32'(bus.irq), 32'd0);

      // Channel 0 directed vectors.
      for (int i = 0; i < 13; i++) begin
         apply_stimulus({3'b0, vecs[i].start0}, {3'b0, vecs[i].stop0},
                        {3'b0, vecs[i].mode0}, {3'b0, vecs[i].clr0});
         bus.value[7:0] = vecs[i].val0;
         step();
         check_output($sformatf("vec%0d busy0", i),  32'(bus.busy[0]),    32'(vecs[i].e_busy));
         check_output($sformatf("vec%0d tick0", i),  32'(bus.tick[0]),    32'(vecs[i].e_tick));
         check_output($sformatf("vec%0d done0", i),  32'(bus.done[0]),    32'(vecs[i].e_done));
         check_output($sformatf("vec%0d irq", i),    32'(bus.irq),        32'(vecs[i].e_irq));
         check_output($sformatf("vec%0d count0", i), 32'(bus.count[7:0]), 32'(vecs[i].e_count));
      end
      apply_stimulus('0, '0, '0, 4'b0001);
      step();
      apply_stimulus('0, '0, '0, '0);

      // Channel 1 periodic value 3, then stopped at count 2.
      bus.value[15:8] = 8'd3;
      apply_stimulus(4'b0010, '0, 4'b0010, '0);
      step();
      apply_stimulus('0, '0, 4'b0010, '0);
      ticks[1] = 0;
      repeat (20) begin
         step();
         if (bus.tick[1]) ticks[1]++;
      end
      check_output("ch1 periodic ticks", 32'(ticks[1]), 32'd5);
      found = 0;
      for (int n = 0; n < 8 && !found; n++) begin
         if (bus.count[15:8] == 8'd2) found = 1;
         else step();
      end
      check_output("ch1 reached count 2", 32'(found), 32'd1);
      bus.stop[1] = 1'b1;
      step();
      bus.stop[1] = 1'b0;
      check_output("ch1 stopped busy", 32'(bus.busy[1]), 32'd0);
      ticks[1] = 0;
      repeat (6) begin
         step();
         if (bus.tick[1]) ticks[1]++;
      end
      check_output("ch1 no tick after stop", 32'(ticks[1]), 32'd0);
      check_output("ch1 count held", 32'(bus.count[15:8]), 32'd2);

      // Channel 2 one-shot value 10 restarted at count 7.
      bus.value[23:16] = 8'd10;
      apply_stimulus(4'b0100, '0, '0, '0);
      step();
      bus.start[2] = 1'b0;
      found = 0;
      for (int n = 0; n < 12 && !found; n++) begin
         if (bus.count[23:16] == 8'd7) found = 1;
         else step();
      end
      check_output("ch2 reached count 7", 32'(found), 32'd1);
      bus.start[2] = 1'b1;
      step();
      bus.start[2] = 1'b0;
      check_output("ch2 restart count", 32'(bus.count[23:16]), 32'd0);
      ticks[2] = 0;
      tick_at = -1;
      for (int n = 1; n <= 15; n++) begin
         step();
         if (bus.tick[2]) begin
            ticks[2]++;
            tick_at = n;
         end
      end
      check_output("ch2 tick count", 32'(ticks[2]), 32'd1);
      check_output("ch2 tick latency", 32'(tick_at), 32'd11);
      apply_stimulus(4'b0100, 4'b0100, '0, '0);
      step();
      check_output("ch2 start beats stop", 32'(bus.busy[2]), 32'd1);
      apply_stimulus('0, 4'b0100, '0, '0);
      step();

      // Channel 3 periodic value 0 with irq_clr held; value change ignored mid-run.
      bus.value[31:24] = 8'd0;
      apply_stimulus(4'b1000, '0, 4'b1000, 4'b1000);
      step();
      bus.start[3] = 1'b0;
      for (int n = 0; n < 6; n++) begin
         if (n == 2) bus.value[31:24] = 8'd9;
         step();
         check_output($sformatf("ch3 tick %0d", n), 32'(bus.tick[3]), 32'd1);
         check_output($sformatf("ch3 done %0d", n), 32'(bus.done[3]), 32'd1);
      end
      apply_stimulus('0, 4'b1000, '0, '1);
      step();
      apply_stimulus('0, '0, '0, '0);

      // All channels started, reset arrives five cycles later.
      bus.value = 32'h0806_0402;
      apply_stimulus('1, '0, '0, '0);
      step();
      apply_stimulus('0, '0, '0, '0);
      for (int c = 0; c < NCH; c++) ticks[c] = 0;
      repeat (4) begin
         step();
         for (int c = 0; c < NCH; c++) if (bus.tick[c]) ticks[c]++;
      end
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int c = 0; c < NCH; c++) check_output($sformatf("ch%0d ticks before reset", c),
                                                  32'(ticks[c]), (c == 0) ? 32'd1 : 32'd0);
      check_output("all zero after reset", {bus.busy, bus.tick, bus.done, bus.irq}, 32'd0);
      check_output("count zero after reset", 32'(bus.count), 32'd0);

      // Randomized traffic.
      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < NCH; c++) begin
            bus.start[c]   = ($urandom_range(7) == 0);
            bus.stop[c]    = ($urandom_range(15) == 0);
            bus.mode[c]    = $urandom_range(1);
            bus.irq_clr[c] = ($urandom_range(7) == 0);
            bus.value[c*WIDTH +: WIDTH] = ($urandom_range(9) == 0) ? WIDTH'($urandom)
                                                                   : WIDTH'($urandom_range(12));
         end
         reset = ($urandom_range(199) != 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
